// File: rtl/pipo.sv
// pipo: chain of DEPTH parallel-in parallel-out registers, each WIDTH bits wide.
// Latency: DEPTH edges from capture to q. No backpressure: every rising edge captures din.
module pipo #(
  parameter int                 WIDTH       = 4,
  parameter int                 DEPTH       = 1,
  parameter logic [WIDTH-1:0]   RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage[i] <= RESET_VALUE;
      end
    end else begin
      stage[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  // q comes straight off the last flop, no output logic
  assign q = stage[DEPTH-1];

endmodule

// File: tb/tb_pipo.sv
`timescale 1ns/1ps
module tb_pipo;

  logic       clk     = 1'b0;
  logic       clk_run = 1'b1;
  logic       rst     = 1'b1;
  logic [3:0] din     = 4'h0;
  logic [3:0] q1;
  logic [3:0] q3;

  int  vectors     = 0;
  int  miscompares = 0;
  bit  mon_en      = 1'b0;
  time last_evt    = 0;

  // words captured since the last reset, newest at the back
  logic [3:0] hist[$];

  typedef struct {
    logic [3:0] din;
    logic [3:0] exp1;
    logic [3:0] exp3;
  } vec_t;

  vec_t tbl[6];

  pipo #(.WIDTH(4), .DEPTH(1), .RESET_VALUE(4'h0)) dut1 (
    .clk(clk), .rst(rst), .din(din), .q(q1)
  );

  pipo #(.WIDTH(4), .DEPTH(3), .RESET_VALUE(4'h0)) dut3 (
    .clk(clk), .rst(rst), .din(din), .q(q3)
  );

  always #10 clk = clk_run ? ~clk : 1'b0;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // A DEPTH-d line shows the word captured d edges ago, or the reset value
  // until d words have been captured since reset.
  function automatic logic [3:0] exp_q(input int d);
    if (hist.size() >= d) return hist[hist.size() - d];
    return 4'h0;
  endfunction

  always @(posedge clk or posedge rst) begin
    last_evt = $time;
    if (rst) begin
      hist.delete();
    end else begin
      hist.push_back(din);
      if (hist.size() > 4) void'(hist.pop_front());
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      chk("mon_d1", q1, exp_q(1));
      chk("mon_d3", q3, exp_q(3));
    end
  end

  // outputs may only move at a clock or reset edge
  always @(q1 or q3) begin
    if (mon_en) begin
      vectors++;
      if ($time != last_evt) begin
        miscompares++;
        $display("FAIL glitch: q1=%h q3=%h changed at %0t, last edge at %0t", q1, q3, $time, last_evt);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    tbl[0] = '{din: 4'h5, exp1: 4'h5, exp3: 4'h0};
    tbl[1] = '{din: 4'hC, exp1: 4'hC, exp3: 4'h0};
    tbl[2] = '{din: 4'h3, exp1: 4'h3, exp3: 4'h5};
    tbl[3] = '{din: 4'h9, exp1: 4'h9, exp3: 4'hC};
    tbl[4] = '{din: 4'h0, exp1: 4'h0, exp3: 4'h3};
    tbl[5] = '{din: 4'hF, exp1: 4'hF, exp3: 4'h9};

    // power-up reset with clock running and junk on din
    din = 4'bxxxx;
    repeat (3) begin
      @(negedge clk);
      chk("por_q1", q1, 4'h0);
      chk("por_q3", q3, 4'h0);
    end

    // release away from the rising edge, then basic capture table
    mon_en = 1'b1;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      din = tbl[i].din;
      @(negedge clk);
      chk("tbl_d1", q1, tbl[i].exp1);
      chk("tbl_d3", q3, tbl[i].exp3);
    end

    // async reset with the clock stopped low
    din = 4'hA;
    repeat (3) @(negedge clk);
    clk_run = 1'b0;
    #5;
    chk("pre_arst_d1", q1, 4'hA);
    chk("pre_arst_d3", q3, 4'hA);
    rst = 1'b1;
    #1;
    chk("arst_d1", q1, 4'h0);
    chk("arst_d3", q3, 4'h0);
    #9;
    rst = 1'b0;
    #5;
    clk_run = 1'b1;

    // exhaustive walk
    @(negedge clk);
    for (int v = 0; v < 16; v++) begin
      din = 4'(v);
      @(negedge clk);
      chk("walk_d1", q1, 4'(v));
    end

    // random words every cycle
    repeat (40) begin
      din = 4'($urandom_range(0, 15));
      @(negedge clk);
    end

    // din changes every 50 ns, always 5 ns away from any clock edge
    @(posedge clk);
    #5;
    repeat (12) begin
      din = 4'($urandom_range(0, 15));
      #50;
    end

    // mid-stream reset on the DEPTH=3 line
    @(negedge clk);
    din = 4'h1;
    @(negedge clk);
    din = 4'h2;
    @(negedge clk);
    din = 4'h3;
    @(posedge clk);
    #1;
    chk("mid_pre_d3", q3, 4'h1);
    #4;
    rst = 1'b1;
    #1;
    chk("mid_rst_d1", q1, 4'h0);
    chk("mid_rst_d3", q3, 4'h0);
    #9;
    rst = 1'b0;
    din = 4'h7;
    @(posedge clk);
    #1;
    chk("mid_e1_d1", q1, 4'h7);
    chk("mid_e1_d3", q3, 4'h0);
    @(negedge clk);
    din = 4'h8;
    @(posedge clk);
    #1;
    chk("mid_e2_d3", q3, 4'h0);
    @(negedge clk);
    din = 4'h9;
    @(posedge clk);
    #1;
    chk("mid_e3_d1", q1, 4'h9);
    chk("mid_e3_d3", q3, 4'h7);

    @(negedge clk);
    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
